// File: rtl/alu_sel_pkg.sv
// ---------------------------------------------------------------------------
// alu_sel_pkg
//   Shared definitions for the pipelined ALU result-select block.
//   - Default parameter values for the top level.
//   - State encoding of the two-entry elastic buffer.
//   - Payload layout {err, data} at the default result width.
// ---------------------------------------------------------------------------
package alu_sel_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_NUM_IN    = 8;
  localparam int DEF_ERR_CNT_W = 8;

  // EMPTY: nothing held; ONE: main register valid; TWO: main and skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // Payload as it travels through the buffer: select-error flag on top of
  // the selected result.
  typedef struct packed {
    logic                 err;
    logic [DEF_WIDTH-1:0] data;
  } alu_payload_t;

endpackage

// File: rtl/alu_skid_buf.sv
// ---------------------------------------------------------------------------
// alu_skid_buf
//   Generic two-entry elastic buffer (main register M + skid register S).
//   Output is driven straight from M, so out_payload is registered.
//
//   Handshake: a transfer happens on a side when valid && ready are both
//   high at a rising clock edge. Once out_valid is high, out_payload stays
//   stable until out_ready is seen. in_ready is a function of the state
//   register and rst only (no path from in_valid or out_ready).
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   in_payload   payload offered by the producer
//   in_valid     producer has a payload this cycle
//   in_ready     buffer can take a payload this cycle
//   out_payload  oldest held payload (contents of M)
//   out_valid    out_payload is valid
//   out_ready    consumer takes out_payload this cycle
//   dbg_state    current FSM state (skid_state_t encoding)
// ---------------------------------------------------------------------------
module alu_skid_buf
  import alu_sel_pkg::*;
#(
  parameter int PW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] in_payload,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    dbg_state
);

  skid_state_t   state_q, state_d;
  logic [PW-1:0] m_q, s_q;
  logic          accept, pop;
  logic          load_m_in, load_m_s, load_s;

  // In TWO the skid entry is occupied, so the producer must stall.
  assign in_ready    = (state_q != TWO) && !rst;
  assign out_valid   = (state_q != EMPTY);
  assign out_payload = m_q;
  assign dbg_state   = state_q;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_m_in = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          // M drains and refills in the same cycle: full throughput.
          load_m_in = 1'b1;
        end else if (accept) begin
          // M is stuck; park the new payload behind it.
          load_s  = 1'b1;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          // S moves up into M; the producer was stalled so nothing new arrives.
          load_m_s = 1'b1;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load_m_in) begin
        m_q <= in_payload;
      end else if (load_m_s) begin
        m_q <= s_q;
      end
      if (load_s) begin
        s_q <= in_payload;
      end
    end
  end

endmodule

// File: rtl/alu_result_select_pipe.sv
// ---------------------------------------------------------------------------
// alu_result_select_pipe
//   Selects one of NUM_IN ALU operation results with opsel and hands it to
//   writeback through a registered valid/ready stage with a one-entry skid
//   buffer. Selects that do not name an existing input yield zero data with
//   out_sel_err set, and are counted in a saturating counter.
//
//   Handshake: input accepted when in_valid && in_ready at a rising edge;
//   output consumed when out_valid && out_ready at a rising edge. Output
//   payload is held stable while out_valid is high and out_ready is low.
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   in_data      NUM_IN results, slice k = in_data[k*WIDTH +: WIDTH]
//   opsel        result select, sampled together with in_data
//   in_valid     in_data/opsel valid
//   in_ready     block can accept this cycle (0 while rst is high)
//   out_data     selected result
//   out_sel_err  out_data came from an out-of-range opsel
//   out_valid    out_data/out_sel_err valid
//   out_ready    downstream accepts this cycle
//   err_count    saturating count of accepted out-of-range selects
//   dbg_state    buffer FSM state (skid_state_t encoding)
// ---------------------------------------------------------------------------
module alu_result_select_pipe
  import alu_sel_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_IN    = DEF_NUM_IN,
  parameter int SEL_W     = $clog2(NUM_IN),
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        opsel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ERR_CNT_W-1:0]    err_count,
  output logic [1:0]              dbg_state
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [WIDTH:0]   buf_out;

  // Only opsel values that match an existing slice clear the error flag;
  // codes past NUM_IN-1 (possible when NUM_IN is not a power of two) fall
  // through with zero data.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (opsel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  alu_skid_buf #(
    .PW (WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_payload  ({sel_err, sel_data}),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_payload (buf_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dbg_state   (dbg_state)
  );

  assign out_sel_err = buf_out[WIDTH];
  assign out_data    = buf_out[WIDTH-1:0];

  // Counts at acceptance time, not at output, so it reflects what entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (in_valid && in_ready && sel_err && (err_count != ERR_MAX)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
